// File: rtl/inst_mem_loader.sv
// Instruction-load endpoint: captures streamed words into an instruction RAM, then serves fetches.
// Optional macro INST_MEM_FETCH_FAULT_EN adds a fetch_fault output for misaligned/out-of-image PCs.
module inst_mem_loader #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 1024,
    parameter logic [XLEN-1:0] END_MARKER = 32'hDEADBEAF,
    parameter logic [XLEN-1:0] NOP_INST   = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_wen,
    input  logic [XLEN-1:0]          inst_data,
    input  logic                     start,
    input  logic                     fetch_req,
    input  logic [XLEN-1:0]          fetch_pc,
    output logic                     fetch_valid,
    output logic [XLEN-1:0]          fetch_inst,
    output logic [XLEN-1:0]          fetch_pc_q,
    output logic [$clog2(DEPTH):0]   load_count,
    output logic                     running,
`ifdef INST_MEM_FETCH_FAULT_EN
    output logic                     fetch_fault,
`endif
    output logic                     load_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SEALED = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Selects what fetch_inst presents: reset value, RAM read data or the NOP filler.
    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_RAM  = 2'd1;
    localparam logic [1:0] SEL_NOP  = 2'd2;

    logic [XLEN-1:0] mem [DEPTH];

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic [XLEN-1:0] rdata_q;
    logic [1:0]      sel_q;
    logic            fetch_valid_q;
    logic [XLEN-1:0] pc_out_q;
    logic            running_q;
    logic            overflow_q;

    logic            is_marker_s;
    logic            full_s;
    logic            wr_en_s;
    logic            rd_en_s;
    logic [XLEN-3:0] count_ext_s;
    logic            in_image_s;
    logic            use_ram_s;

    assign is_marker_s = (inst_data == END_MARKER);
    assign full_s      = (count_q == CW'(DEPTH));
    assign wr_en_s     = (state_q == ST_LOAD) && inst_wen && !is_marker_s && !full_s;
    assign rd_en_s     = (state_q == ST_RUN) && fetch_req;
    assign count_ext_s = {{(XLEN-2-CW){1'b0}}, count_q};
    assign in_image_s  = (fetch_pc[XLEN-1:2] < count_ext_s);

`ifdef INST_MEM_FETCH_FAULT_EN
    logic fault_s;
    logic fault_q;
    assign fault_s     = (fetch_pc[1:0] != 2'b00) || !in_image_s;
    assign use_ram_s   = !fault_s;
    assign fetch_fault = fault_q;
`else
    assign use_ram_s   = in_image_s;
`endif

    // The load count doubles as the write pointer; it never wraps because writes stop when full.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[count_q[AW-1:0]] <= inst_data;
        end
    end

    // Synchronous read port, only active in RUN so it never collides with a write.
    always_ff @(posedge clk) begin
        if (rd_en_s) begin
            rdata_q <= mem[fetch_pc[AW+1:2]];
        end
    end

    // Load/seal/run control plus registered fetch response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            count_q       <= '0;
            sel_q         <= SEL_ZERO;
            fetch_valid_q <= 1'b0;
            pc_out_q      <= '0;
            running_q     <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef INST_MEM_FETCH_FAULT_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            fetch_valid_q <= rd_en_s;
`ifdef INST_MEM_FETCH_FAULT_EN
            fault_q       <= rd_en_s && fault_s;
`endif
            if (rd_en_s) begin
                pc_out_q <= fetch_pc;
                sel_q    <= use_ram_s ? SEL_RAM : SEL_NOP;
            end
            if (wr_en_s) begin
                count_q <= count_q + CW'(1);
            end
            case (state_q)
                ST_LOAD: begin
                    if (inst_wen && !is_marker_s && full_s) begin
                        overflow_q <= 1'b1;
                    end
                    if (start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (inst_wen && is_marker_s) begin
                        state_q <= ST_SEALED;
                    end
                end
                ST_SEALED: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    running_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_LOAD;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Output mux over registered sources only.
    always_comb begin
        fetch_inst = '0;
        case (sel_q)
            SEL_RAM:  fetch_inst = rdata_q;
            SEL_NOP:  fetch_inst = NOP_INST;
            default:  fetch_inst = '0;
        endcase
    end

    assign fetch_valid   = fetch_valid_q;
    assign fetch_pc_q    = pc_out_q;
    assign load_count    = count_q;
    assign running       = running_q;
    assign load_overflow = overflow_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader (DEPTH=4); covers fetch_fault when INST_MEM_FETCH_FAULT_EN is defined.
module tb_inst_mem_loader;

    localparam logic [31:0] MARK = 32'hDEADBEAF;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] I0   = 32'h00500093;
    localparam logic [31:0] I1   = 32'h00108113;
    localparam logic [31:0] I2   = 32'h002081B3;
    localparam logic [31:0] X1   = 32'h00A00513;
    localparam logic [31:0] WA   = 32'h11111111;
    localparam logic [31:0] WB   = 32'h22222222;
    localparam logic [31:0] WC   = 32'h33333333;
    localparam logic [31:0] WD   = 32'h44444444;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_wen;
    logic [31:0] inst_data;
    logic        start;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc_q;
    logic [2:0]  load_count;
    logic        running;
    logic        load_overflow;
`ifdef INST_MEM_FETCH_FAULT_EN
    logic        fetch_fault;
`endif

    int errors = 0;
    int checks = 0;

    inst_mem_loader #(.XLEN(32), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_wen      (inst_wen),
        .inst_data     (inst_data),
        .start         (start),
        .fetch_req     (fetch_req),
        .fetch_pc      (fetch_pc),
        .fetch_valid   (fetch_valid),
        .fetch_inst    (fetch_inst),
        .fetch_pc_q    (fetch_pc_q),
        .load_count    (load_count),
        .running       (running),
`ifdef INST_MEM_FETCH_FAULT_EN
        .fetch_fault   (fetch_fault),
`endif
        .load_overflow (load_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; inst_wen = 1'b0; inst_data = 32'h0; start = 1'b0;
        fetch_req = 1'b0; fetch_pc = 32'h0;
        step(); step();
        rst = 1'b0;
        check("rst_valid", {31'h0, fetch_valid}, 32'h0);
        check("rst_inst", fetch_inst, 32'h0);
        check("rst_pcq", fetch_pc_q, 32'h0);
        check("rst_count", {29'h0, load_count}, 32'd0);
        check("rst_running", {31'h0, running}, 32'h0);
        check("rst_ovf", {31'h0, load_overflow}, 32'h0);

        // Load three words then the marker; fetch_req in LOAD must be ignored
        inst_wen = 1'b1; inst_data = I0; fetch_req = 1'b1; fetch_pc = 32'h0;
        step();
        check("gate_load", {31'h0, fetch_valid}, 32'h0);
        fetch_req = 1'b0; inst_data = I1; step();
        inst_data = I2; step();
        inst_data = MARK; step();
        inst_wen = 1'b0;
        check("marker_count", {29'h0, load_count}, 32'd3);
        check("sealed_running", {31'h0, running}, 32'h0);
        fetch_req = 1'b1; step();
        check("gate_sealed", {31'h0, fetch_valid}, 32'h0);
        fetch_req = 1'b0; start = 1'b1; step();
        start = 1'b0;
        check("run_running", {31'h0, running}, 32'h1);

        fetch_req = 1'b1; fetch_pc = 32'd0; step();
        check("f0_valid", {31'h0, fetch_valid}, 32'h1);
        check("f0_inst", fetch_inst, I0);
        check("f0_pcq", fetch_pc_q, 32'd0);
        fetch_pc = 32'd4; step();
        check("f4_valid", {31'h0, fetch_valid}, 32'h1);
        check("f4_inst", fetch_inst, I1);
        check("f4_pcq", fetch_pc_q, 32'd4);
        fetch_pc = 32'd12; step();
        check("f12_inst", fetch_inst, NOP);
        check("f12_pcq", fetch_pc_q, 32'd12);
        fetch_pc = 32'd16; step();
        check("f16_inst", fetch_inst, NOP);
        fetch_pc = 32'd8; step();
        check("f8_inst", fetch_inst, I2);
        fetch_req = 1'b0; step();
        check("idle_valid", {31'h0, fetch_valid}, 32'h0);
        check("idle_hold", fetch_inst, I2);

        // Reset while a fetch result is pending
        fetch_req = 1'b1; fetch_pc = 32'd4; step();
        check("mid_valid", {31'h0, fetch_valid}, 32'h1);
        fetch_req = 1'b0; rst = 1'b1; step();
        check("mr_valid", {31'h0, fetch_valid}, 32'h0);
        check("mr_running", {31'h0, running}, 32'h0);
        check("mr_count", {29'h0, load_count}, 32'd0);
        check("mr_inst", fetch_inst, 32'h0);
        rst = 1'b0;
        inst_wen = 1'b1; inst_data = X1; start = 1'b1; step();
        inst_wen = 1'b0; start = 1'b0;
        check("one_count", {29'h0, load_count}, 32'd1);
        check("one_running", {31'h0, running}, 32'h1);
        fetch_req = 1'b1; fetch_pc = 32'd4; step();
        check("one_f4", fetch_inst, NOP);
        fetch_pc = 32'd0; step();
        check("one_f0", fetch_inst, X1);
        fetch_req = 1'b0;

        // Start in the same cycle as the third write, no marker
        rst = 1'b1; step(); rst = 1'b0;
        inst_wen = 1'b1; inst_data = WA; step();
        inst_data = WB; step();
        inst_data = WC; start = 1'b1; step();
        start = 1'b0;
        check("sw_count", {29'h0, load_count}, 32'd3);
        check("sw_running", {31'h0, running}, 32'h1);
        inst_data = WD; step();
        inst_wen = 1'b0;
        check("sw_ignored", {29'h0, load_count}, 32'd3);
        fetch_req = 1'b1; fetch_pc = 32'd8; step();
        check("sw_f8", fetch_inst, WC);
        fetch_pc = 32'd9; step();
`ifdef INST_MEM_FETCH_FAULT_EN
        check("sw_f9_nop", fetch_inst, NOP);
        check("sw_f9_fault", {31'h0, fetch_fault}, 32'h1);
`else
        check("sw_f9", fetch_inst, WC);
`endif
        fetch_pc = 32'd0; step();
        check("sw_f0", fetch_inst, WA);
`ifdef INST_MEM_FETCH_FAULT_EN
        check("sw_f0_fault", {31'h0, fetch_fault}, 32'h0);
`endif
        fetch_req = 1'b0;

        // Overflow: six writes into a four-word RAM
        rst = 1'b1; step(); rst = 1'b0;
        check("ov_rst_ovf", {31'h0, load_overflow}, 32'h0);
        inst_wen = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_data = 32'hA0000000 + 32'(i);
            step();
        end
        check("ov_full_count", {29'h0, load_count}, 32'd4);
        check("ov_full_flag", {31'h0, load_overflow}, 32'h0);
        for (int i = 4; i < 6; i++) begin
            inst_data = 32'hA0000000 + 32'(i);
            step();
        end
        inst_wen = 1'b0;
        check("ov_count", {29'h0, load_count}, 32'd4);
        check("ov_flag", {31'h0, load_overflow}, 32'h1);
        start = 1'b1; step(); start = 1'b0;
        fetch_req = 1'b1; fetch_pc = 32'd12; step();
        check("ov_f12", fetch_inst, 32'hA0000003);
        fetch_pc = 32'd16; step();
        check("ov_f16", fetch_inst, NOP);
`ifdef INST_MEM_FETCH_FAULT_EN
        check("ov_f16_fault", {31'h0, fetch_fault}, 32'h1);
`endif
        fetch_req = 1'b0; step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
